// File: rtl/lh_pkg.sv
// ---------------------------------------------------------------------------
// lh_pkg
// Shared definitions for the light-hash round sequencer:
//   LH_START / LH_FINISH  framing bytes of a message
//   LH_IV                 initial hash state, H[0] in bits 63:56
//   lh_state_e            controller states (2-bit encoding)
//   is_alnum()            character class accepted for absorption
//   rotl8()               8-bit rotate left, amount 0 leaves the byte as is
// ---------------------------------------------------------------------------
package lh_pkg;

  localparam logic [7:0]  LH_START  = 8'hFF;
  localparam logic [7:0]  LH_FINISH = 8'h00;
  localparam logic [63:0] LH_IV     = 64'h0123_4567_89AB_CDEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    ROUND  = 2'd2
  } lh_state_e;

  // True for '0'-'9', 'A'-'Z' and 'a'-'z'.
  function automatic logic is_alnum(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h5A)) ||
           ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  // Rotating a doubled copy lets the bits leaving the top re-enter at the
  // bottom without a separate wrap term.
  function automatic logic [7:0] rotl8(input logic [7:0] b, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {b, b} << amount;
    return doubled[15:8];
  endfunction

endpackage

// File: rtl/lh_update_step.sv
// ---------------------------------------------------------------------------
// lh_update_step
// Combinational part of one byte update: t = rotl8(H[(i+2)%8] ^ c, i).
// Ports:
//   i_hSrc  in  8  state byte H[(i+2)%8]
//   i_char  in  8  character being absorbed
//   i_idx   in  3  byte index i, also the rotate amount
//   o_t     out 8  S-box index for this step
// ---------------------------------------------------------------------------
module lh_update_step
  import lh_pkg::*;
(
  input  logic [7:0] i_hSrc,
  input  logic [7:0] i_char,
  input  logic [2:0] i_idx,
  output logic [7:0] o_t
);

  assign o_t = rotl8(i_hSrc ^ i_char, i_idx);

endmodule

// File: rtl/lh_round_sequencer.sv
// ---------------------------------------------------------------------------
// lh_round_sequencer
// Accepts a framed character stream (0xFF start, 0x00 finish) and absorbs
// each alphanumeric character with ROUNDS x 8 byte updates, one per cycle,
// through an external shared S-box. Publishes the 64-bit digest on finish.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_char/in_valid  character stream input, in_ready is the back-pressure
//   sbox_in/sbox_out  request/response of the external combinational S-box
//   digest            {H[0],...,H[7]} latched on finish, digest_valid pulses
//   err_invalid_char  pulses when a non-alphanumeric byte is dropped
//   busy              high while the round updates run
// ---------------------------------------------------------------------------
module lh_round_sequencer
  import lh_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int IDX_W  = $clog2(ROUNDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  sbox_in,
  input  logic [7:0]  sbox_out,
  output logic [63:0] digest,
  output logic        digest_valid,
  output logic        err_invalid_char,
  output logic        busy
);

  lh_state_e        r_state, w_stateNext;
  logic [7:0]       r_h [8];
  logic [7:0]       w_hNext [8];
  logic [IDX_W-1:0] r_round, w_roundNext;
  logic [2:0]       r_idx, w_idxNext;
  logic [7:0]       r_char, w_charNext;
  logic [63:0]      r_digest, w_digestNext;
  logic             r_digestValid, w_digestValidNext;
  logic             r_errInvalid, w_errInvalidNext;
  logic             w_xfer;
  logic [2:0]       w_srcIdx;
  logic [7:0]       w_stepT;

  // Ready is gated by rst so nothing is accepted, and the output reads 0,
  // while reset is held; it rises as soon as reset is released.
  assign in_ready = !rst && (r_state != ROUND);
  assign w_xfer   = in_valid && in_ready;
  assign busy     = (r_state == ROUND);

  // The 3-bit add wraps modulo 8, giving (i+2)%8 for free.
  assign w_srcIdx = r_idx + 3'd2;

  lh_update_step u_step (
    .i_hSrc (r_h[w_srcIdx]),
    .i_char (r_char),
    .i_idx  (r_idx),
    .o_t    (w_stepT)
  );

  // The S-box is shared, so present a quiet index when not using it.
  assign sbox_in          = busy ? w_stepT : 8'h00;
  assign digest           = r_digest;
  assign digest_valid     = r_digestValid;
  assign err_invalid_char = r_errInvalid;

  // Next-state logic: framing decisions in IDLE/ABSORB, one in-place byte
  // update per cycle in ROUND. Pulses default low so they last one cycle.
  always_comb begin
    w_stateNext       = r_state;
    w_hNext           = r_h;
    w_roundNext       = r_round;
    w_idxNext         = r_idx;
    w_charNext        = r_char;
    w_digestNext      = r_digest;
    w_digestValidNext = 1'b0;
    w_errInvalidNext  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_xfer && (in_char == LH_START)) begin
          for (int k = 0; k < 8; k++) w_hNext[k] = LH_IV[63-8*k -: 8];
          w_stateNext = ABSORB;
        end
      end

      ABSORB: begin
        if (w_xfer) begin
          if (in_char == LH_START) begin
            for (int k = 0; k < 8; k++) w_hNext[k] = LH_IV[63-8*k -: 8];
          end else if (in_char == LH_FINISH) begin
            for (int k = 0; k < 8; k++) w_digestNext[63-8*k -: 8] = r_h[k];
            w_digestValidNext = 1'b1;
            w_stateNext       = IDLE;
          end else if (is_alnum(in_char)) begin
            w_charNext  = in_char;
            w_roundNext = '0;
            w_idxNext   = 3'd0;
            w_stateNext = ROUND;
          end else begin
            w_errInvalidNext = 1'b1;
          end
        end
      end

      ROUND: begin
        w_hNext[r_idx] = sbox_out;
        w_idxNext      = r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          w_roundNext = r_round + 1'b1;
          if (r_round == IDX_W'(ROUNDS - 1)) w_stateNext = ABSORB;
        end
      end

      default: w_stateNext = IDLE;
    endcase
  end

  // State register; reset also clears the published digest.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      for (int k = 0; k < 8; k++) r_h[k] <= LH_IV[63-8*k -: 8];
      r_round       <= '0;
      r_idx         <= 3'd0;
      r_char        <= 8'h00;
      r_digest      <= 64'h0;
      r_digestValid <= 1'b0;
      r_errInvalid  <= 1'b0;
    end else begin
      r_state       <= w_stateNext;
      r_h           <= w_hNext;
      r_round       <= w_roundNext;
      r_idx         <= w_idxNext;
      r_char        <= w_charNext;
      r_digest      <= w_digestNext;
      r_digestValid <= w_digestValidNext;
      r_errInvalid  <= w_errInvalidNext;
    end
  end

endmodule

// File: tb/tb_lh_round_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lh_round_sequencer
// Drives framed messages into lh_round_sequencer, serves the S-box requests
// from a locally built AES S-box, and compares against a loop-based model of
// the light-hash algorithm.
// ---------------------------------------------------------------------------
module tb_lh_round_sequencer;

  localparam int ROUNDS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_char = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;
  logic [63:0] digest;
  logic        digest_valid;
  logic        err_invalid_char;
  logic        busy;

  logic [7:0]  sboxTbl [256];
  logic [7:0]  ivBytes [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  int          testCount = 0;
  int          failCount = 0;
  int          dvSeen = 0;
  int          errSeen = 0;
  int          overlapSeen = 0;

  lh_round_sequencer #(.ROUNDS(ROUNDS)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_char          (in_char),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .sbox_in          (sbox_in),
    .sbox_out         (sbox_out),
    .digest           (digest),
    .digest_valid     (digest_valid),
    .err_invalid_char (err_invalid_char),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // External S-box modelled as a combinational table lookup.
  assign sbox_out = sboxTbl[sbox_in];

  // Event counters sampled mid-cycle; tasks read them after a #1 settle.
  always @(negedge clk) begin
    if (digest_valid) dvSeen++;
    if (err_invalid_char) errSeen++;
    if (busy && in_ready) overlapSeen++;
  end

  // GF(2^8) multiply with the AES polynomial, used to build the S-box.
  function automatic int gmul(input int a, input int b);
    int p = 0;
    int x = a;
    int y = b;
    for (int k = 0; k < 8; k++) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 9'h11B;
      y = y >> 1;
    end
    return p & 255;
  endfunction

  function automatic int rot8(input int x, input int n);
    return ((x << n) | (x >> (8 - n))) & 255;
  endfunction

  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s;
      for (int y = 1; y < 256; y++) if (x != 0 && gmul(x, y) == 1) inv = y;
      s = inv ^ rot8(inv, 1) ^ rot8(inv, 2) ^ rot8(inv, 3) ^ rot8(inv, 4) ^ 8'h63;
      sboxTbl[x] = 8'(s);
    end
  endtask

  function automatic bit tbAlnum(input int b);
    return (b >= 48 && b <= 57) || (b >= 65 && b <= 90) || (b >= 97 && b <= 122);
  endfunction

  // Reference: absorb each alphanumeric byte of the body with ROUNDS passes
  // over the 8 state bytes, updating in place.
  function automatic logic [63:0] modelDigest(input logic [7:0] body[$]);
    int h[8];
    logic [63:0] d;
    for (int k = 0; k < 8; k++) h[k] = ivBytes[k];
    foreach (body[n]) begin
      if (tbAlnum(body[n])) begin
        for (int r = 0; r < ROUNDS; r++)
          for (int i = 0; i < 8; i++)
            h[i] = sboxTbl[rot8(h[(i + 2) % 8] ^ body[n], i)];
      end
    end
    for (int k = 0; k < 8; k++) d[63-8*k -: 8] = 8'(h[k]);
    return d;
  endfunction

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    while (!in_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    testCount++;
    if (!in_ready) begin
      failCount++;
      $display("[TB] FAIL ready_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
    end
    in_valid = 1'b1;
    in_char  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_char  = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    testCount++; if (in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
    testCount++; if (digest !== 64'h0) begin failCount++; $display("[TB] FAIL reset_digest: got %h want 0", digest); end
    testCount++; if (digest_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_dv: got %0b want 0", digest_valid); end
    testCount++; if (err_invalid_char !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err: got %0b want 0", err_invalid_char); end
    testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    testCount++; if (sbox_in !== 8'h00) begin failCount++; $display("[TB] FAIL reset_sbox_in: got %h want 00", sbox_in); end
    rst = 1'b0;
    @(negedge clk);
    testCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL post_reset_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_empty_message();
    int dv0, err0;
    #1; dv0 = dvSeen; err0 = errSeen;
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    testCount++; if (digest_valid !== 1'b1) begin failCount++; $display("[TB] FAIL empty_dv: got %0b want 1", digest_valid); end
    testCount++; if (digest !== 64'h0123_4567_89AB_CDEF) begin failCount++; $display("[TB] FAIL empty_digest: got %h want 0123456789abcdef", digest); end
    @(negedge clk); #1;
    testCount++; if (dvSeen - dv0 != 1) begin failCount++; $display("[TB] FAIL empty_dv_pulses: got %0d want 1", dvSeen - dv0); end
    testCount++; if (errSeen - err0 != 0) begin failCount++; $display("[TB] FAIL empty_err_pulses: got %0d want 0", errSeen - err0); end
  endtask

  task automatic test_round_timing();
    int h[8];
    int busyCycles = 0;
    int readyBad = 0;
    int traceBad = 0;
    int firstBad = -1;
    int expT;
    int i = 0;
    logic [7:0] body[$];
    for (int k = 0; k < 8; k++) h[k] = ivBytes[k];
    applyStimulus(8'hFF);
    applyStimulus(8'h61);
    while (busy && busyCycles < 1000) begin
      if (in_ready !== 1'b0) readyBad++;
      expT = rot8(h[(i + 2) % 8] ^ 8'h61, i);
      if (sbox_in !== 8'(expT)) begin
        traceBad++;
        if (firstBad < 0) firstBad = busyCycles;
      end
      h[i] = sboxTbl[expT];
      i = (i + 1) % 8;
      busyCycles++;
      @(negedge clk);
    end
    testCount++; if (busyCycles != 8 * ROUNDS) begin failCount++; $display("[TB] FAIL busy_length: got %0d cycles want %0d", busyCycles, 8 * ROUNDS); end
    testCount++; if (readyBad != 0) begin failCount++; $display("[TB] FAIL ready_during_round: got %0d high cycles want 0", readyBad); end
    testCount++; if (traceBad != 0) begin failCount++; $display("[TB] FAIL sbox_trace: got %0d wrong indices (first at step %0d) want 0", traceBad, firstBad); end
    testCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL ready_after_round: got %0b want 1", in_ready); end
    applyStimulus(8'h00);
    body = '{8'h61};
    testCount++; if (digest !== modelDigest(body)) begin failCount++; $display("[TB] FAIL digest_a: got %h want %h", digest, modelDigest(body)); end
  endtask

  task automatic test_invalid_char();
    int err0;
    logic [7:0] body[$];
    #1; err0 = errSeen;
    applyStimulus(8'hFF);
    applyStimulus(8'h23);
    testCount++; if (err_invalid_char !== 1'b1) begin failCount++; $display("[TB] FAIL invalid_err_pulse: got %0b want 1", err_invalid_char); end
    testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL invalid_busy: got %0b want 0", busy); end
    @(negedge clk);
    testCount++; if (err_invalid_char !== 1'b0) begin failCount++; $display("[TB] FAIL invalid_err_width: got %0b want 0", err_invalid_char); end
    applyStimulus(8'h61);
    applyStimulus(8'h00);
    body = '{8'h61};
    testCount++; if (digest !== modelDigest(body)) begin failCount++; $display("[TB] FAIL invalid_digest: got %h want %h", digest, modelDigest(body)); end
    #1;
    testCount++; if (errSeen - err0 != 1) begin failCount++; $display("[TB] FAIL invalid_err_count: got %0d want 1", errSeen - err0); end
  endtask

  task automatic test_idle_ignore();
    int dv0, err0;
    logic [63:0] held;
    logic [7:0] body[$];
    body = '{8'h61};
    held = modelDigest(body);
    #1; dv0 = dvSeen; err0 = errSeen;
    applyStimulus(8'h51);
    testCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL idle_q_busy: got %0b want 0", busy); end
    applyStimulus(8'h00);
    @(negedge clk); #1;
    testCount++; if (dvSeen - dv0 != 0) begin failCount++; $display("[TB] FAIL idle_finish_ignored: got %0d pulses want 0", dvSeen - dv0); end
    testCount++; if (errSeen - err0 != 0) begin failCount++; $display("[TB] FAIL idle_err: got %0d pulses want 0", errSeen - err0); end
    testCount++; if (digest !== held) begin failCount++; $display("[TB] FAIL idle_digest_held: got %h want %h", digest, held); end
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    testCount++; if (digest !== 64'h0123_4567_89AB_CDEF) begin failCount++; $display("[TB] FAIL idle_then_empty: got %h want 0123456789abcdef", digest); end
  endtask

  task automatic test_reset_mid_round();
    applyStimulus(8'hFF);
    applyStimulus(8'h7A);
    repeat (99) @(negedge clk);
    testCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL mid_round_busy: got %0b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    testCount++; if (busy !== 1'b0 || in_ready !== 1'b0 || sbox_in !== 8'h00 || digest_valid !== 1'b0 || err_invalid_char !== 1'b0)
      begin failCount++; $display("[TB] FAIL abort_outputs: got busy=%0b ready=%0b sbox=%h dv=%0b err=%0b want all 0", busy, in_ready, sbox_in, digest_valid, err_invalid_char); end
    testCount++; if (digest !== 64'h0) begin failCount++; $display("[TB] FAIL abort_digest: got %h want 0", digest); end
    rst = 1'b0;
    @(negedge clk);
    testCount++; if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL abort_ready: got %0b want 1", in_ready); end
    applyStimulus(8'hFF);
    applyStimulus(8'h00);
    testCount++; if (digest !== 64'h0123_4567_89AB_CDEF) begin failCount++; $display("[TB] FAIL abort_then_empty: got %h want 0123456789abcdef", digest); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [5] = '{8'hFF, 8'h41, 8'hFF, 8'h41, 8'h00};
    int acceptAt [5] = '{0, 0, 0, 0, 0};
    int k = 0;
    int cyc = 0;
    int ov0;
    logic [7:0] body[$];
    #1; ov0 = overlapSeen;
    in_valid = 1'b1;
    in_char  = seq[0];
    while (k < 5 && cyc < 3000) begin
      if (in_ready) begin
        acceptAt[k] = cyc;
        k++;
      end
      @(negedge clk);
      cyc++;
      if (k < 5) in_char = seq[k];
    end
    in_valid = 1'b0;
    testCount++; if (k != 5) begin failCount++; $display("[TB] FAIL b2b_transfers: got %0d want 5", k); end
    testCount++; if (digest_valid !== 1'b1) begin failCount++; $display("[TB] FAIL b2b_dv: got %0b want 1", digest_valid); end
    body = '{8'h41};
    testCount++; if (digest !== modelDigest(body)) begin failCount++; $display("[TB] FAIL b2b_digest: got %h want %h", digest, modelDigest(body)); end
    testCount++; if (acceptAt[2] - acceptAt[1] != 8 * ROUNDS + 1) begin failCount++; $display("[TB] FAIL b2b_gap1: got %0d want %0d", acceptAt[2] - acceptAt[1], 8 * ROUNDS + 1); end
    testCount++; if (acceptAt[4] - acceptAt[3] != 8 * ROUNDS + 1) begin failCount++; $display("[TB] FAIL b2b_gap2: got %0d want %0d", acceptAt[4] - acceptAt[3], 8 * ROUNDS + 1); end
    @(negedge clk); #1;
    testCount++; if (overlapSeen - ov0 != 0) begin failCount++; $display("[TB] FAIL b2b_ready_while_busy: got %0d cycles want 0", overlapSeen - ov0); end
  endtask

  task automatic test_random_messages();
    string alnum = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
    for (int m = 0; m < 3; m++) begin
      logic [7:0] body[$];
      int err0;
      int expErr = 0;
      int len = $urandom_range(1, 3);
      body = {};
      for (int n = 0; n < len; n++) begin
        logic [7:0] b;
        if ($urandom_range(0, 3) == 0) begin
          b = 8'($urandom_range(1, 254));
          while (tbAlnum(b)) b = 8'($urandom_range(1, 254));
          expErr++;
        end else begin
          b = alnum[$urandom_range(0, 61)];
        end
        body.push_back(b);
      end
      #1; err0 = errSeen;
      applyStimulus(8'hFF);
      foreach (body[n]) applyStimulus(body[n]);
      applyStimulus(8'h00);
      testCount++; if (digest !== modelDigest(body)) begin failCount++; $display("[TB] FAIL random_digest_%0d: got %h want %h", m, digest, modelDigest(body)); end
      #1;
      testCount++; if (errSeen - err0 != expErr) begin failCount++; $display("[TB] FAIL random_err_%0d: got %0d want %0d", m, errSeen - err0, expErr); end
      @(negedge clk);
    end
  endtask

  initial begin
    buildSbox();
    @(negedge clk);
    test_reset();
    test_empty_message();
    test_round_timing();
    test_invalid_char();
    test_idle_ignore();
    test_reset_mid_round();
    test_back_to_back();
    test_random_messages();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
